dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  - Shares the single-port data_memory between two requesters:
//    - the pipeline MEM stage (port P);
//    - a debug/loader port (port D), used for program load and state dump.
//  - Registered req/ready/valid handshake per port; one transaction in flight at a time.
//  - Drives memwrite/memread/add/write_data of data_memory from registers only.
//    This keeps the level-sensitive memory write glitch-free.
// PARAMETERS
//  DATA_W  64  data width of both ports and of the memory
//  ADDR_W  64  address width; the memory decodes only add[9:0]
// PORTS
//  clock           in   1       system clock; all state changes on posedge
//  reset           in   1       synchronous, active-high reset
//  p_req           in   1       pipeline access request; held until p_ready
//  p_we            in   1       1 = write, 0 = read
//  p_addr          in   ADDR_W  pipeline address
//  p_wdata         in   DATA_W  pipeline write data
//  p_ready         out  1       1-cycle pulse: P request accepted
//  p_valid         out  1       1-cycle pulse: P transaction complete
//  p_rdata         out  DATA_W  read data, meaningful while p_valid
//  d_req/d_we/d_addr/d_wdata/d_ready/d_valid/d_rdata   same as P, debug port
//  mem_memwrite    out  1       to data_memory.memwrite
//  mem_memread     out  1       to data_memory.memread
//  mem_add         out  ADDR_W  to data_memory.add
//  mem_write_data  out  DATA_W  to data_memory.write_data
//  mem_read_data   in   DATA_W  from data_memory.read_data (combinational)
// BEHAVIOUR
//  - Reset: all outputs are 0; FSM goes to IDLE; RR pointer goes to P.
//  - FSM states: IDLE -> ACCESS -> RESP -> IDLE. Throughput is 1 transaction per 3 cycles.
//  - IDLE:
//    - If any req is high, pick a winner (see CONFIGURATION).
//    - Latch the winner's we/addr/wdata and its owner id.
//    - Pulse the winner's ready in this same cycle, then go to ACCESS.
//    - The loser sees no ready and must keep req high.
//  - ACCESS (exactly 1 cycle):
//    - mem_add and mem_write_data come from the latched registers.
//    - mem_memwrite = latched we; mem_memread = ~latched we.
//    - On a read, capture mem_read_data into the response register at the end of the cycle.
//    - Go to RESP.
//  - RESP (1 cycle):
//    - Pulse the owner's valid; drive the owner's rdata from the response register.
//    - A write completes with rdata = 0.
//    - The other port's valid stays 0 and its rdata is 0.
//    - Go to IDLE. A req may be accepted in the following cycle.
//  - Latency: req accepted in cycle N -> memory driven in N+1 -> valid in N+2.
//  - Outside ACCESS: mem_memwrite = mem_memread = 0, and mem_add/mem_write_data hold their last values.
//  - Requester inputs are don't-care after their ready pulse; the block never re-samples them.
//  - A req that drops before its ready pulse is a legal withdrawal; nothing is latched for it.
//  - Reset mid-transaction (ACCESS or RESP):
//    - the transaction is dropped and no valid is issued;
//    - memwrite is low from the next cycle.
//  - Address is passed through unmodified at full ADDR_W; no range checking; wrap is done by the memory.
// CONFIGURATION
//  - DMEM_ARB_RR_EN undefined: fixed priority.
//    - P always wins a simultaneous request.
//    - D is served only when p_req = 0 in IDLE.
//  - DMEM_ARB_RR_EN defined: round-robin.
//    - A 1-bit pointer names the preferred port and flips to the other port after each grant.
//    - A port is never skipped twice while both are requesting.
// TESTING
//  - P read at addr 5 after reset -> p_ready at N, mem_memread = 1 at N+1, p_valid at N+2 with p_rdata = 5.
//  - D write 0xDEAD to addr 3, then P read of addr 3 -> d_valid with d_rdata = 0; later p_rdata = 0xDEAD.
//  - p_req and d_req high together for 4 transactions:
//    - without macro: order P,P,P,P;
//    - with DMEM_ARB_RR_EN: order P,D,P,D.
//  - reset asserted during ACCESS of a P write to addr 7 ->
//    - no p_valid;
//    - all outputs 0 the next cycle;
//    - mem_memwrite high for at most that one cycle.
//  - back-to-back P reads of addr 1 and addr 2 -> p_valid at N+2 and N+5, p_rdata = 1 then 2, no overlap.
//  - check that mem_memwrite is never high outside ACCESS, and is never high together with mem_memread.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports (pipeline P, debug D)
// and the data_memory side of the arbiter.
// slave modport  = arbiter view, master modport = requesters/memory view.
interface dmem_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    // Pipeline (P) port
    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_ready;
    logic              p_valid;
    logic [DATA_W-1:0] p_rdata;

    // Debug/loader (D) port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    // data_memory side
    logic              mem_memwrite;
    logic              mem_memread;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_ready, p_valid, p_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ready, d_valid, d_rdata,
        output mem_memwrite, mem_memread, mem_add, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_ready, p_valid, p_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ready, d_valid, d_rdata,
        input  mem_memwrite, mem_memread, mem_add, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data_memory between the pipeline
// MEM stage (P) and the debug/loader port (D). One transaction in flight,
// IDLE -> ACCESS -> RESP, so one transaction every 3 cycles.
// All memory-side strobes come straight from flops so the level-sensitive
// memory write never sees a combinational glitch.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration;
// otherwise P has fixed priority over D.
module dmem_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic OWNER_P = 1'b0;
    localparam logic OWNER_D = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q;
    logic              memWrite_q;
    logic              memRead_q;
    logic [ADDR_W-1:0] memAdd_q;
    logic [DATA_W-1:0] memWdata_q;
    logic              pValid_q, dValid_q;
    logic [DATA_W-1:0] pRdata_q, dRdata_q;

    logic              anyReq;
    logic              grant;
    logic              winner;
    logic              winWe;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winWdata;
    logic              inAccess;

`ifdef DMEM_ARB_RR_EN
    logic              rrPtr_q;

    // Preferred-port pointer: after each grant the other port becomes preferred
    always_ff @(posedge clock) begin
        if (reset) begin
            rrPtr_q <= OWNER_P;
        end else if (grant) begin
            rrPtr_q <= ~winner;
        end
    end

    // Round-robin pick: the pointer breaks ties, a lone requester always wins
    always_comb begin
        winner = OWNER_P;
        if (bus.p_req && bus.d_req) begin
            winner = rrPtr_q;
        end else if (bus.d_req) begin
            winner = OWNER_D;
        end
    end
`else
    // Fixed priority pick: D only wins when P is not requesting
    always_comb begin
        winner = bus.p_req ? OWNER_P : OWNER_D;
    end
`endif

    // Grant decision and the winner's request fields; reset blocks any acceptance
    always_comb begin
        anyReq   = bus.p_req | bus.d_req;
        grant    = (state_q == IDLE) && anyReq && !reset;
        inAccess = (state_q == ACCESS);
        winWe    = bus.p_we;
        winAddr  = bus.p_addr;
        winWdata = bus.p_wdata;
        if (winner == OWNER_D) begin
            winWe    = bus.d_we;
            winAddr  = bus.d_addr;
            winWdata = bus.d_wdata;
        end
    end

    // Transaction sequencing: exactly one ACCESS and one RESP cycle per grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the winner at grant, strobe the memory for one cycle,
    // then capture the response into the owner's result register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWNER_P;
            memWrite_q <= 1'b0;
            memRead_q  <= 1'b0;
            memAdd_q   <= '0;
            memWdata_q <= '0;
            pValid_q   <= 1'b0;
            dValid_q   <= 1'b0;
            pRdata_q   <= '0;
            dRdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            memWrite_q <= grant & winWe;
            memRead_q  <= grant & ~winWe;
            if (grant) begin
                owner_q    <= winner;
                memAdd_q   <= winAddr;
                memWdata_q <= winWdata;
            end
            pValid_q <= inAccess && (owner_q == OWNER_P);
            dValid_q <= inAccess && (owner_q == OWNER_D);
            pRdata_q <= (inAccess && (owner_q == OWNER_P) && memRead_q) ? bus.mem_read_data : '0;
            dRdata_q <= (inAccess && (owner_q == OWNER_D) && memRead_q) ? bus.mem_read_data : '0;
        end
    end

    assign bus.p_ready        = grant && (winner == OWNER_P);
    assign bus.d_ready        = grant && (winner == OWNER_D);
    assign bus.p_valid        = pValid_q;
    assign bus.d_valid        = dValid_q;
    assign bus.p_rdata        = pRdata_q;
    assign bus.d_rdata        = dRdata_q;
    assign bus.mem_memwrite   = memWrite_q;
    assign bus.mem_memread    = memRead_q;
    assign bus.mem_add        = memAdd_q;
    assign bus.mem_write_data = memWdata_q;

endmodule
